// File: rtl/rv32_imm_gen_if.sv
// Decode-stage immediate bus: instruction/pc in, five registered immediates out.
interface rv32_imm_gen_if;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] i_imm;
    logic [31:0] u_imm;
    logic [31:0] s_imm;
    logic [31:0] sb_imm;
    logic [31:0] uj_imm;

    modport master (
        output pc,
        output instruction,
        input  i_imm,
        input  u_imm,
        input  s_imm,
        input  sb_imm,
        input  uj_imm
    );

    modport slave (
        input  pc,
        input  instruction,
        output i_imm,
        output u_imm,
        output s_imm,
        output sb_imm,
        output uj_imm
    );
endinterface

// File: rtl/rv32_imm_gen.sv
// RV32I immediate generator: all five formats in parallel, B/J already pc-relative,
// registered once with a synchronous active-high reset.
module rv32_imm_gen (
    input  logic          clk,
    input  logic          rst,
    rv32_imm_gen_if.slave bus
);

    logic [31:0] instr;
    logic [31:0] i_imm_d, u_imm_d, s_imm_d, sb_imm_d, uj_imm_d;
    logic [31:0] i_imm_q, u_imm_q, s_imm_q, sb_imm_q, uj_imm_q;
    logic [31:0] b_off, j_off;
    logic        unused_opcode;

    assign instr = bus.instruction;

    // The opcode field never contributes to any immediate.
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        i_imm_d  = {{20{instr[31]}}, instr[31:20]};
        s_imm_d  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        u_imm_d  = {instr[31:12], 12'h000};
        b_off    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        j_off    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        // Targets wrap modulo 2^32; pc bit 0 passes through untouched.
        sb_imm_d = bus.pc + b_off;
        uj_imm_d = bus.pc + j_off;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_imm_q  <= 32'h0;
            u_imm_q  <= 32'h0;
            s_imm_q  <= 32'h0;
            sb_imm_q <= 32'h0;
            uj_imm_q <= 32'h0;
        end else begin
            i_imm_q  <= i_imm_d;
            u_imm_q  <= u_imm_d;
            s_imm_q  <= s_imm_d;
            sb_imm_q <= sb_imm_d;
            uj_imm_q <= uj_imm_d;
        end
    end

    assign bus.i_imm  = i_imm_q;
    assign bus.u_imm  = u_imm_q;
    assign bus.s_imm  = s_imm_q;
    assign bus.sb_imm = sb_imm_q;
    assign bus.uj_imm = uj_imm_q;

endmodule

// File: tb/tb_rv32_imm_gen.sv
// Directed bench for rv32_imm_gen: reset, four hand-computed vectors, back-to-back
// streaming and a mid-stream reset.
module tb_rv32_imm_gen;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rv32_imm_gen_if bus ();

    rv32_imm_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Vector table: pc, instruction, then expected i, s, u, sb, uj.
    logic [31:0] v_pc   [4] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    logic [31:0] v_ins  [4] = '{32'h000003E7, 32'h80000000, 32'h40000000, 32'hFFFFFFFF};
    logic [31:0] e_i    [4] = '{32'h00000000, 32'hFFFFF800, 32'h00000400, 32'hFFFFFFFF};
    logic [31:0] e_s    [4] = '{32'h00000007, 32'hFFFFF800, 32'h00000400, 32'hFFFFFFFF};
    logic [31:0] e_u    [4] = '{32'h00000000, 32'h80000000, 32'h40000000, 32'hFFFFF000};
    logic [31:0] e_sb   [4] = '{32'h00000805, 32'hFFFFF000, 32'h00000400, 32'hFFFFFFFD};
    logic [31:0] e_uj   [4] = '{32'hFFFFFFFF, 32'hFFF00000, 32'h00000400, 32'hFFFFFFFD};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input int idx);
        check({tag, " i_imm"},  bus.i_imm,  e_i[idx]);
        check({tag, " s_imm"},  bus.s_imm,  e_s[idx]);
        check({tag, " u_imm"},  bus.u_imm,  e_u[idx]);
        check({tag, " sb_imm"}, bus.sb_imm, e_sb[idx]);
        check({tag, " uj_imm"}, bus.uj_imm, e_uj[idx]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " i_imm"},  bus.i_imm,  32'h0);
        check({tag, " s_imm"},  bus.s_imm,  32'h0);
        check({tag, " u_imm"},  bus.u_imm,  32'h0);
        check({tag, " sb_imm"}, bus.sb_imm, 32'h0);
        check({tag, " uj_imm"}, bus.uj_imm, 32'h0);
    endtask

    task automatic apply(input int idx);
        bus.pc          = v_pc[idx];
        bus.instruction = v_ins[idx];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        apply(3);
        tick();
        check_zero("rst edge1");
        tick();
        check_zero("rst edge2");

        rst = 1'b0;
        tick();
        check_vec("post-rst ones", 3);

        // Back-to-back: each result must appear one edge after its vector.
        for (int k = 0; k < 4; k++) begin
            apply(k);
            tick();
            check_vec($sformatf("b2b v%0d", k), k);
        end

        // Mid-stream reset while vector 2 is presented.
        apply(0);
        tick();
        check_vec("mid v0", 0);
        apply(1);
        tick();
        check_vec("mid v1", 1);
        rst = 1'b1;
        apply(2);
        tick();
        check_zero("mid rst");
        rst = 1'b0;
        tick();
        check_vec("resume v2", 2);
        apply(3);
        tick();
        check_vec("resume v3", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
